de_hazard_reg: RTL and testbench

DE_HAZARD_REG -- requirements
Module: de_hazard_reg

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/instr_decode.sv | 102 ++++++++++
 rtl/de_hazard_reg.sv | 175 +++++++++++++++++
 tb/tb_de_hazard_reg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants, Tuse/Tnew encodings and decode types
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Register numbers with special meaning
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Cycles until a produced value can be forwarded
  localparam logic [1:0] TNEW_0   = 2'd0;
  localparam logic [1:0] TNEW_1   = 2'd1;
  localparam logic [1:0] TNEW_2   = 2'd2;

  // Cycles until an operand is consumed; NEVER is larger than any Tnew,
  // so a plain Tuse < Tnew compare can never stall on an unused operand.
  localparam logic [1:0] TUSE_0     = 2'd0;
  localparam logic [1:0] TUSE_1     = 2'd1;
  localparam logic [1:0] TUSE_2     = 2'd2;
  localparam logic [1:0] TUSE_NEVER = 2'd3;

  typedef enum logic [3:0] {
    CLS_NOP  = 4'd0,
    CLS_ADDU = 4'd1,
    CLS_SUBU = 4'd2,
    CLS_ORI  = 4'd3,
    CLS_LW   = 4'd4,
    CLS_SW   = 4'd5,
    CLS_BEQ  = 4'd6,
    CLS_LUI  = 4'd7,
    CLS_JAL  = 4'd8,
    CLS_JR   = 4'd9,
    CLS_J    = 4'd10
  } instr_cls_e;

  // A result one stage further down the pipe is one cycle closer to ready.
  function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
    return (tnew == TNEW_0) ? TNEW_0 : (tnew - 2'd1);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - instruction class, source/destination registers, Tnew and Tuse
module instr_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  cls_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  a3_o,
  output logic [1:0]  tnew_o,
  output logic [1:0]  tuse_rs_o,
  output logic [1:0]  tuse_rt_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  instr_cls_e cls;
  logic       unused_instr;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign rd    = instr_i[15:11];
  assign rs_o  = instr_i[25:21];
  assign rt_o  = instr_i[20:16];
  assign cls_o = cls;

  // shamt is irrelevant to every supported instruction
  assign unused_instr = ^instr_i[10:6];

  // Classify the encoding; anything outside the supported set behaves as nop
  always_comb begin
    cls = CLS_NOP;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_NOP;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_LUI:  cls = CLS_LUI;
      OP_JAL:  cls = CLS_JAL;
      OP_J:    cls = CLS_J;
      default: cls = CLS_NOP;
    endcase
  end

  // Destination register, result latency and operand deadlines per class
  always_comb begin
    a3_o      = REG_ZERO;
    tnew_o    = TNEW_0;
    tuse_rs_o = TUSE_NEVER;
    tuse_rt_o = TUSE_NEVER;
    case (cls)
      CLS_ADDU, CLS_SUBU: begin
        a3_o      = rd;
        tnew_o    = TNEW_1;
        tuse_rs_o = TUSE_1;
        tuse_rt_o = TUSE_1;
      end
      CLS_ORI: begin
        a3_o      = rt_o;
        tnew_o    = TNEW_1;
        tuse_rs_o = TUSE_1;
      end
      CLS_LW: begin
        a3_o      = rt_o;
        tnew_o    = TNEW_2;
        tuse_rs_o = TUSE_1;
      end
      CLS_LUI: begin
        a3_o      = rt_o;
        tnew_o    = TNEW_1;
      end
      CLS_SW: begin
        tuse_rs_o = TUSE_1;
        tuse_rt_o = TUSE_2;
      end
      CLS_BEQ: begin
        tuse_rs_o = TUSE_0;
        tuse_rt_o = TUSE_0;
      end
      CLS_JR: begin
        tuse_rs_o = TUSE_0;
      end
      CLS_JAL: begin
        a3_o      = REG_RA;
        tnew_o    = TNEW_0;
      end
      default: begin
        a3_o      = REG_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/de_hazard_reg.sv
// rtl/de_hazard_reg.sv - D/E pipeline register with Tuse/Tnew stall detection; optional stall counter under DE_STALL_CNT_EN
module de_hazard_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_PC8,
  input  logic [31:0] D_RD1_forward,
  input  logic [31:0] D_RD2_forward,
  input  logic [31:0] D_Ext,
  output logic        Stall,
  output logic [31:0] EX_Instr_o,
  output logic [31:0] EX_PC8_o,
  output logic [31:0] EX_RD1_o,
  output logic [31:0] EX_RD2_o,
  output logic [31:0] EX_Ext_o,
  output logic [4:0]  EX_RegAddr_o,
  output logic [1:0]  EX_Tnew_o
`ifdef DE_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  // E-stage registers
  logic [31:0] ex_instr_q, ex_instr_d;
  logic [31:0] ex_pc8_q,   ex_pc8_d;
  logic [31:0] ex_rd1_q,   ex_rd1_d;
  logic [31:0] ex_rd2_q,   ex_rd2_d;
  logic [31:0] ex_ext_q,   ex_ext_d;
  logic [4:0]  ex_a3_q,    ex_a3_d;
  logic [1:0]  ex_tnew_q,  ex_tnew_d;

  // M-stage shadow: only what hazard detection needs from the next stage
  logic [4:0]  m_a3_q,     m_a3_d;
  logic [1:0]  m_tnew_q,   m_tnew_d;

  // Decode of the instruction in D
  logic [3:0]  d_cls;
  logic [4:0]  d_rs, d_rt, d_a3;
  logic [1:0]  d_tnew, d_tuse_rs, d_tuse_rt;

  // Decode of the instruction in E (bubble decodes as nop: A3 0, Tnew 0)
  logic [3:0]  e_cls;
  logic [4:0]  e_rs, e_rt, e_a3;
  logic [1:0]  e_tnew, e_tuse_rs, e_tuse_rt;

  logic        rs_hazard, rt_hazard;
  logic        unused_dec;

  instr_decode u_dec_d (
    .instr_i   (D_Instr),
    .cls_o     (d_cls),
    .rs_o      (d_rs),
    .rt_o      (d_rt),
    .a3_o      (d_a3),
    .tnew_o    (d_tnew),
    .tuse_rs_o (d_tuse_rs),
    .tuse_rt_o (d_tuse_rt)
  );

  instr_decode u_dec_e (
    .instr_i   (ex_instr_q),
    .cls_o     (e_cls),
    .rs_o      (e_rs),
    .rt_o      (e_rt),
    .a3_o      (e_a3),
    .tnew_o    (e_tnew),
    .tuse_rs_o (e_tuse_rs),
    .tuse_rt_o (e_tuse_rt)
  );

  // Fields of the decoders that hazard detection has no use for
  assign unused_dec = ^{d_cls, e_cls, e_rs, e_rt, e_tuse_rs, e_tuse_rt};

  // Stall when a nonzero D source is produced in E or M later than D needs it;
  // depends only on D inputs and registered state
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    if (d_rs != REG_ZERO) begin
      rs_hazard = ((d_rs == e_a3)   && (d_tuse_rs < e_tnew)) ||
                  ((d_rs == m_a3_q) && (d_tuse_rs < m_tnew_q));
    end
    if (d_rt != REG_ZERO) begin
      rt_hazard = ((d_rt == e_a3)   && (d_tuse_rt < e_tnew)) ||
                  ((d_rt == m_a3_q) && (d_tuse_rt < m_tnew_q));
    end
    Stall = rs_hazard | rt_hazard;
  end

  // Next E contents: the D instruction when free to issue, otherwise a bubble
  always_comb begin
    ex_instr_d = '0;
    ex_pc8_d   = '0;
    ex_rd1_d   = '0;
    ex_rd2_d   = '0;
    ex_ext_d   = '0;
    ex_a3_d    = REG_ZERO;
    ex_tnew_d  = TNEW_0;
    if (!Stall) begin
      ex_instr_d = D_Instr;
      ex_pc8_d   = D_PC8;
      ex_rd1_d   = D_RD1_forward;
      ex_rd2_d   = D_RD2_forward;
      ex_ext_d   = D_Ext;
      ex_a3_d    = d_a3;
      ex_tnew_d  = d_tnew;
    end
  end

  // The shadow follows E every cycle, stalled or not
  always_comb begin
    m_a3_d   = ex_a3_q;
    m_tnew_d = tnew_age(ex_tnew_q);
  end

  // E registers and M shadow; reset overrides both load and bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_instr_q <= '0;
      ex_pc8_q   <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_ext_q   <= '0;
      ex_a3_q    <= REG_ZERO;
      ex_tnew_q  <= TNEW_0;
      m_a3_q     <= REG_ZERO;
      m_tnew_q   <= TNEW_0;
    end else begin
      ex_instr_q <= ex_instr_d;
      ex_pc8_q   <= ex_pc8_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_ext_q   <= ex_ext_d;
      ex_a3_q    <= ex_a3_d;
      ex_tnew_q  <= ex_tnew_d;
      m_a3_q     <= m_a3_d;
      m_tnew_q   <= m_tnew_d;
    end
  end

  assign EX_Instr_o   = ex_instr_q;
  assign EX_PC8_o     = ex_pc8_q;
  assign EX_RD1_o     = ex_rd1_q;
  assign EX_RD2_o     = ex_rd2_q;
  assign EX_Ext_o     = ex_ext_q;
  assign EX_RegAddr_o = ex_a3_q;
  assign EX_Tnew_o    = ex_tnew_q;

`ifdef DE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count stalled edges, holding at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_de_hazard_reg.sv
// tb/tb_de_hazard_reg.sv - directed self-checking bench for de_hazard_reg
module tb_de_hazard_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] D_Instr, D_PC8, D_RD1_forward, D_RD2_forward, D_Ext;
  logic        Stall;
  logic [31:0] EX_Instr_o, EX_PC8_o, EX_RD1_o, EX_RD2_o, EX_Ext_o;
  logic [4:0]  EX_RegAddr_o;
  logic [1:0]  EX_Tnew_o;
`ifdef DE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-encoded instructions
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] LW8      = 32'h8C08_0000; // lw   $8,0($0)
  localparam logic [31:0] LW0      = 32'h8C00_0000; // lw   $0,0($0)
  localparam logic [31:0] ADDU9    = 32'h0108_4821; // addu $9,$8,$8
  localparam logic [31:0] ADDU1    = 32'h0000_0821; // addu $1,$0,$0
  localparam logic [31:0] SUBU10   = 32'h0129_5023; // subu $10,$9,$9
  localparam logic [31:0] BEQ8     = 32'h1100_0003; // beq  $8,$0,3
  localparam logic [31:0] ORI5     = 32'h3405_0007; // ori  $5,$0,7
  localparam logic [31:0] SW5      = 32'hAC05_0000; // sw   $5,0($0)
  localparam logic [31:0] SW8_RT   = 32'hAC08_0000; // sw   $8,0($0)
  localparam logic [31:0] SW5_RS8  = 32'hAD05_0000; // sw   $5,0($8)
  localparam logic [31:0] JAL      = 32'h0C00_0100; // jal  0x400
  localparam logic [31:0] JR31     = 32'h03E0_0008; // jr   $31
  localparam logic [31:0] LUI3     = 32'h3C03_1234; // lui  $3,0x1234
  localparam logic [31:0] J        = 32'h0800_0040; // j    0x100
  localparam logic [31:0] BADOP    = 32'hFC00_0000; // unsupported opcode

  de_hazard_reg dut (
    .clk           (clk),
    .reset         (reset),
    .D_Instr       (D_Instr),
    .D_PC8         (D_PC8),
    .D_RD1_forward (D_RD1_forward),
    .D_RD2_forward (D_RD2_forward),
    .D_Ext         (D_Ext),
    .Stall         (Stall),
    .EX_Instr_o    (EX_Instr_o),
    .EX_PC8_o      (EX_PC8_o),
    .EX_RD1_o      (EX_RD1_o),
    .EX_RD2_o      (EX_RD2_o),
    .EX_Ext_o      (EX_Ext_o),
    .EX_RegAddr_o  (EX_RegAddr_o),
    .EX_Tnew_o     (EX_Tnew_o)
`ifdef DE_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand/immediate values are derived from PC+8 so every field is distinct
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc8);
    D_Instr       = instr;
    D_PC8         = pc8;
    D_RD1_forward = pc8 ^ 32'h1111_0000;
    D_RD2_forward = pc8 ^ 32'h2222_0000;
    D_Ext         = pc8 ^ 32'h3333_0000;
    #1;
  endtask

  task automatic chk_e(input string tag, input logic [31:0] instr, input logic [31:0] pc8,
                       input logic [4:0] a3, input logic [1:0] tnew);
    chk({tag, ".instr"}, EX_Instr_o, instr);
    chk({tag, ".pc8"},   EX_PC8_o,   pc8);
    chk({tag, ".rd1"},   EX_RD1_o,   pc8 ^ 32'h1111_0000);
    chk({tag, ".rd2"},   EX_RD2_o,   pc8 ^ 32'h2222_0000);
    chk({tag, ".ext"},   EX_Ext_o,   pc8 ^ 32'h3333_0000);
    chk({tag, ".a3"},    {27'd0, EX_RegAddr_o}, {27'd0, a3});
    chk({tag, ".tnew"},  {30'd0, EX_Tnew_o},    {30'd0, tnew});
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".instr"}, EX_Instr_o, 32'd0);
    chk({tag, ".pc8"},   EX_PC8_o,   32'd0);
    chk({tag, ".rd1"},   EX_RD1_o,   32'd0);
    chk({tag, ".rd2"},   EX_RD2_o,   32'd0);
    chk({tag, ".ext"},   EX_Ext_o,   32'd0);
    chk({tag, ".a3"},    {27'd0, EX_RegAddr_o}, 32'd0);
    chk({tag, ".tnew"},  {30'd0, EX_Tnew_o},    32'd0);
  endtask

  logic [31:0] misc_instr [4];
  logic [4:0]  misc_a3    [4];
  logic [1:0]  misc_tnew  [4];

  initial begin
    misc_instr = '{SUBU10, LUI3, J, BADOP};
    misc_a3    = '{5'd10, 5'd3, 5'd0, 5'd0};
    misc_tnew  = '{2'd1, 2'd1, 2'd0, 2'd0};

    reset = 1'b1;
    drive(NOP, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_bubble("reset");
    chk("reset.stall", {31'd0, Stall}, 32'd0);

    // lw then dependent addu: one stall, one bubble, then issue
    drive(LW8, 32'h100);
    chk("lw.stall", {31'd0, Stall}, 32'd0);
    tick();
    chk_e("lw", LW8, 32'h100, 5'd8, 2'd2);
    drive(ADDU9, 32'h104);
    chk("lu.stall1", {31'd0, Stall}, 32'd1);
    tick();
    chk_bubble("lu.bubble");
    chk("lu.stall2", {31'd0, Stall}, 32'd0);
    tick();
    chk_e("lu.addu", ADDU9, 32'h104, 5'd9, 2'd1);

    // lw then beq: two stalls (E then M), beq enters E on the third edge
    drive(LW8, 32'h108);
    chk("lb.lwstall", {31'd0, Stall}, 32'd0);
    tick();
    drive(BEQ8, 32'h10C);
    chk("lb.stall1", {31'd0, Stall}, 32'd1);
    tick();
    chk_bubble("lb.bubble1");
    chk("lb.stall2", {31'd0, Stall}, 32'd1);
    tick();
    chk_bubble("lb.bubble2");
    chk("lb.stall3", {31'd0, Stall}, 32'd0);
    tick();
    chk_e("lb.beq", BEQ8, 32'h10C, 5'd0, 2'd0);

    // ori then sw of the result: store data is needed late enough
    drive(ORI5, 32'h110);
    tick();
    chk_e("ori", ORI5, 32'h110, 5'd5, 2'd1);
    drive(SW5, 32'h114);
    chk("os.stall", {31'd0, Stall}, 32'd0);
    tick();
    chk_e("sw", SW5, 32'h114, 5'd0, 2'd0);

    // jal then jr $31: link value is ready immediately
    drive(JAL, 32'h118);
    tick();
    chk_e("jal", JAL, 32'h118, 5'd31, 2'd0);
    drive(JR31, 32'h11C);
    chk("jj.stall", {31'd0, Stall}, 32'd0);
    tick();
    chk_e("jr", JR31, 32'h11C, 5'd0, 2'd0);

    // loads into $0 never create a hazard
    drive(LW0, 32'h120);
    tick();
    chk_e("lw0", LW0, 32'h120, 5'd0, 2'd2);
    drive(ADDU1, 32'h124);
    chk("z.stall", {31'd0, Stall}, 32'd0);
    tick();
    chk_e("addu1", ADDU1, 32'h124, 5'd1, 2'd1);

    // M-only match: lw, unrelated nop, then beq on the load result
    drive(LW8, 32'h128);
    tick();
    drive(NOP, 32'h12C);
    chk("m.nopstall", {31'd0, Stall}, 32'd0);
    tick();
    drive(BEQ8, 32'h130);
    chk("m.stall1", {31'd0, Stall}, 32'd1);
    tick();
    chk_bubble("m.bubble");
    chk("m.stall2", {31'd0, Stall}, 32'd0);
    tick();
    chk_e("m.beq", BEQ8, 32'h130, 5'd0, 2'd0);

    // sw after lw: data operand tolerates it, base operand does not
    drive(LW8, 32'h134);
    tick();
    drive(SW8_RT, 32'h138);
    chk("sw.rt.stall", {31'd0, Stall}, 32'd0);
    drive(SW5_RS8, 32'h138);
    chk("sw.rs.stall", {31'd0, Stall}, 32'd1);
    drive(NOP, 32'h13C);
    tick();
    chk_e("nop", NOP, 32'h13C, 5'd0, 2'd0);

    // remaining classes and an unsupported encoding
    for (int i = 0; i < 4; i++) begin
      drive(misc_instr[i], 32'h140 + 32'(i * 4));
      tick();
      chk_e($sformatf("misc%0d", i), misc_instr[i], 32'h140 + 32'(i * 4), misc_a3[i], misc_tnew[i]);
    end

    // reset during a load-use stall clears everything
    drive(LW8, 32'h200);
    tick();
    drive(ADDU9, 32'h204);
    chk("rs.stallpre", {31'd0, Stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_bubble("rs.clear");
    chk("rs.stallpost", {31'd0, Stall}, 32'd0);
`ifdef DE_STALL_CNT_EN
    chk("rs.cnt0", stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      drive(LW8, 32'h300 + 32'(i * 8));
      tick();
      drive(ADDU9, 32'h304 + 32'(i * 8));
      chk($sformatf("pair%0d.stall", i), {31'd0, Stall}, 32'd1);
      tick();
      tick();
      chk_e($sformatf("pair%0d.addu", i), ADDU9, 32'h304 + 32'(i * 8), 5'd9, 2'd1);
    end
`ifdef DE_STALL_CNT_EN
    chk("rs.cnt3", stall_cnt, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
